// File: rtl/serial_rx_buffer_if.sv
// Serial RX buffer bus: producer strobe, consumer pop, status.
// master drives strobes/clear; slave is the buffer.
interface serial_rx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_dat;
  logic                rx_stb;
  logic                rd_stb;
  logic [7:0]          rd_dat;
  logic                rd_vld;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                hiwat;
  logic                ovf;
  logic                ovf_clr;

  modport master (
    output rx_dat, rx_stb, rd_stb, ovf_clr,
    input  rd_dat, rd_vld, count, full, hiwat, ovf
  );

  modport slave (
    input  rx_dat, rx_stb, rd_stb, ovf_clr,
    output rd_dat, rd_vld, count, full, hiwat, ovf
  );
endinterface

// File: rtl/serial_rx_buffer.sv
// Show-ahead byte FIFO behind the serial RX strobe.
// Ports: clk, rst (async active-low), bus (slave: rx_*, rd_*, count/full/hiwat/ovf).
module serial_rx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIWAT      = 12
) (
  input logic                 clk,
  input logic                 rst,
  serial_rx_buffer_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIWAT_CNT = CW'(HIWAT);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic full, vld, pop, push, drop;

  assign full = (count_q == FULL_CNT);
  assign vld  = (count_q != '0);
  assign pop  = bus.rd_stb & vld;
  // A pop in the same cycle frees the slot for a push even when full.
  assign push = bus.rx_stb & (~full | pop);
  assign drop = bus.rx_stb & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    ovf_d = drop | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= bus.rx_dat;
  end

  assign bus.rd_dat = mem_q[rd_ptr_q];
  assign bus.rd_vld = vld;
  assign bus.count  = count_q;
  assign bus.full   = full;
  assign bus.hiwat  = (count_q >= HIWAT_CNT);
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_rx_buffer.sv
// Scoreboard bench for serial_rx_buffer.
// Queue model holds expected bytes; pops compare rd_dat against the front.
module tb_serial_rx_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  serial_rx_buffer_if #(.DEPTH_LOG2(4)) bus ();

  serial_rx_buffer #(
    .DEPTH_LOG2(4),
    .HIWAT(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [7:0] sbq [$];
  logic       m_ovf = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(sbq.size()));
    check({tag, ".vld"}, 32'(bus.rd_vld), 32'(sbq.size() != 0));
    check({tag, ".full"}, 32'(bus.full), 32'(sbq.size() == 16));
    check({tag, ".hiwat"}, 32'(bus.hiwat), 32'(sbq.size() >= 12));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
    if (sbq.size() != 0)
      check({tag, ".head"}, 32'(bus.rd_dat), 32'(sbq[0]));
  endtask

  task automatic step(input logic rx, input logic [7:0] dat,
                      input logic rd, input logic clr,
                      input string tag);
    bit was_full;
    bit pop;
    bus.rx_stb  = rx;
    bus.rx_dat  = dat;
    bus.rd_stb  = rd;
    bus.ovf_clr = clr;
    was_full = (sbq.size() == 16);
    pop = rd && (sbq.size() != 0);
    if (pop) begin
      check({tag, ".pop"}, 32'(bus.rd_dat), 32'(sbq[0]));
      void'(sbq.pop_front());
    end
    if (rx && (!was_full || pop)) sbq.push_back(dat);
    if (rx && was_full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_stb  = 1'b0;
    bus.rd_stb  = 1'b0;
    bus.ovf_clr = 1'b0;
    check_state(tag);
  endtask

  initial begin
    bus.rx_stb  = 1'b0;
    bus.rx_dat  = 8'h00;
    bus.rd_stb  = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0, "idle");

    step(1, 8'h41, 0, 0, "wr41");
    step(0, 8'h00, 1, 0, "rd41");

    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "fill1");
    step(1, 8'hAA, 0, 0, "dropAA");
    step(1, 8'hBB, 1, 0, "pushpopBB");
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "drain1");

    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, "fill2");
    step(1, 8'hCC, 0, 1, "ovfclr_race");
    step(0, 8'h00, 0, 1, "ovfclr");
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "drain2");

    step(0, 8'h00, 1, 0, "underflow");
    step(1, 8'h55, 1, 0, "empty_pp");
    step(0, 8'h00, 1, 0, "rd55");

    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, "fill3");
    step(1, 8'hDD, 0, 0, "dropDD");
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0, "trim");
    check("five_left", 32'(bus.count), 32'd5);

    #3;
    rst = 1'b0;
    sbq.delete();
    m_ovf = 1'b0;
    #1;
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step(0, 8'h00, 0, 0, "post_rst");
    step(1, 8'h77, 0, 0, "wr77");
    step(0, 8'h00, 1, 0, "rd77");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
